mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter that lets two requesters (bit 0 is the
// UART loader, bit 1 is the reader) share one single-command memory port.
// A transaction walks IDLE -> ISSUE -> WAIT -> RESP. All outputs are registered.
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable a WAIT watchdog. After
// TIMEOUT_CYCLES cycles in WAIT it aborts the transaction with an err_o pulse.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = 28,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  CLK100MHZ,
    input  logic                  CPU_RESETN,
    input  logic [1:0]            req_i,
    input  logic [1:0]            we_i,
    input  logic [2*ADDR_W-1:0]   addr_i,
    input  logic [2*DATA_W-1:0]   wdata_i,
    output logic [1:0]            gnt_o,
    output logic [1:0]            done_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic [1:0]            err_o,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_d_to_ram,
    input  logic [DATA_W-1:0]     mem_d_from_ram,
    input  logic                  mem_transaction_complete
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    state_e              state_q;
    logic                ptr_q;      // last granted requester
    logic                sel_q;      // requester owning the current transaction
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          gnt_q;
    logic [1:0]          done_q;
    logic [1:0]          err_q;
    logic                rd_q;
    logic                wr_q;
    logic                win_d;
    logic [1:0]          sel_oh;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WD_W-1:0]     wd_q;
`endif

    assign sel_oh = sel_q ? 2'b10 : 2'b01;

    // Round-robin pick: on contention the requester not granted last wins.
    always_comb begin
        win_d = 1'b0;
        if (req_i == 2'b11) begin
            win_d = ~ptr_q;
        end else begin
            win_d = req_i[1];
        end
    end

    // Transaction FSM with registered grant/command/completion outputs.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= IDLE;
            ptr_q   <= 1'b1;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            err_q  <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        gnt_q   <= win_d ? 2'b10 : 2'b01;
                        sel_q   <= win_d;
                        ptr_q   <= win_d;
                        we_q    <= we_i[win_d];
                        addr_q  <= win_d ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0];
                        wdata_q <= win_d ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0];
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    wr_q    <= we_q;
                    rd_q    <= ~we_q;
`ifdef MEM_ARB_TIMEOUT_EN
                    wd_q    <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (mem_transaction_complete) begin
                        state_q <= RESP;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        err_q   <= sel_oh;
                        state_q <= IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    // Read data is taken from the RESP cycle so it appears together with done_o.
                    if (!we_q) begin
                        rdata_q <= mem_d_from_ram;
                    end
                    done_q  <= sel_oh;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o        = gnt_q;
    assign done_o       = done_q;
    assign rdata_o      = rdata_q;
    assign mem_read     = rd_q;
    assign mem_write    = wr_q;
    assign mem_addr     = addr_q;
    assign mem_d_to_ram = wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign err_o        = err_q;
`else
    assign err_o        = '0;
`endif

endmodule
